// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array drain path: default result width,
// row type and the per-column de-skew depth.
package sa_pkg;

    localparam int SA_C_WIDTH  = 16;
    localparam int SA_COLS_DEF = 1;

    typedef logic [SA_C_WIDTH-1:0] sa_word_t;
    typedef sa_word_t sa_row_t [SA_COLS_DEF];

    // Column j leaves the array j cycles after column 0, so it waits the remainder.
    function automatic int sa_delay(input int cols, input int col);
        return cols - 1 - col;
    endfunction

endpackage

// File: rtl/sa_drain_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_rd_data whenever
// it is not empty. Data storage is not reset; only pointers and count are.
module sa_drain_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state for pointers and occupancy; callers only assert enables that are legal.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_wr_en) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (i_rd_en) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({i_wr_en, i_rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Row storage.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[wptr_q] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[rptr_q];
    assign o_full    = (count_q == CW'(DEPTH));
    assign o_empty   = (count_q == CW'(0));
    assign o_count   = count_q;

endmodule

// File: rtl/sa_drain.sv
// Systolic-array result collector: de-skews the per-column result streams into
// aligned rows, buffers them in a FIFO and flags dropped or misaligned rows.
module sa_drain
    import sa_pkg::*;
#(
    parameter int SA_COLS = SA_COLS_DEF,
    parameter int C_WIDTH = SA_C_WIDTH,
    parameter int DEPTH   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ctrl_sa_send_data [SA_COLS],
    input  logic [C_WIDTH-1:0]       i_c [SA_COLS],
    input  logic                     i_clr,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [C_WIDTH-1:0]       o_row [SA_COLS],
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_skew_err,
    output logic [15:0]              o_row_cnt
);

    localparam int RW = SA_COLS * C_WIDTH;

    logic [SA_COLS-1:0]              al_v;
    logic [SA_COLS-1:0][C_WIDTH-1:0] al_d;

    for (genvar j = 0; j < SA_COLS; j++) begin : g_col
        localparam int D = sa_delay(SA_COLS, j);
        if (D == 0) begin : g_pass
            assign al_v[j] = i_ctrl_sa_send_data[j];
            assign al_d[j] = i_c[j];
        end else begin : g_dly
            logic [D-1:0]              v_q, v_d;
            logic [D-1:0][C_WIDTH-1:0] d_q, d_d;

            // Shift the {valid, data} pair one stage per cycle.
            always_comb begin
                v_d    = v_q;
                d_d    = d_q;
                v_d[0] = i_ctrl_sa_send_data[j];
                d_d[0] = i_c[j];
                for (int k = 1; k < D; k++) begin
                    v_d[k] = v_q[k-1];
                    d_d[k] = d_q[k-1];
                end
            end

            // Delay-line registers.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    v_q <= '0;
                    d_q <= '0;
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end

            assign al_v[j] = v_q[D-1];
            assign al_d[j] = d_q[D-1];
        end
    end

    logic          all_v_s, any_v_s;
    logic          full_s, empty_s, pop_s, push_s;
    logic          ovf_set_s, skew_set_s;
    logic [RW-1:0] wr_data_s, rd_data_s;
    logic          overflow_q, overflow_d;
    logic          skew_err_q, skew_err_d;
    logic [15:0]   row_cnt_q, row_cnt_d;

    assign all_v_s    = &al_v;
    assign any_v_s    = |al_v;
    assign pop_s      = o_valid & i_ready;
    // A full FIFO still takes the row when the head leaves in the same cycle.
    assign push_s     = all_v_s & (~full_s | pop_s);
    assign ovf_set_s  = all_v_s & full_s & ~pop_s;
    assign skew_set_s = any_v_s & ~all_v_s;
    assign wr_data_s  = al_d;

    sa_drain_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .i_wr_en   (push_s),
        .i_wr_data (wr_data_s),
        .i_rd_en   (pop_s),
        .o_rd_data (rd_data_s),
        .o_full    (full_s),
        .o_empty   (empty_s),
        .o_count   (o_count)
    );

    // Sticky flags and row counter; a set event beats a same-cycle clear.
    always_comb begin
        overflow_d = ovf_set_s  | (overflow_q & ~i_clr);
        skew_err_d = skew_set_s | (skew_err_q & ~i_clr);
        if (i_clr) begin
            row_cnt_d = push_s ? 16'd1 : 16'd0;
        end else if (push_s) begin
            row_cnt_d = row_cnt_q + 16'd1;
        end else begin
            row_cnt_d = row_cnt_q;
        end
    end

    // Flag and counter registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
            row_cnt_q  <= 16'd0;
        end else begin
            overflow_q <= overflow_d;
            skew_err_q <= skew_err_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    // Unpack the head row into per-column elements.
    always_comb begin
        for (int j = 0; j < SA_COLS; j++) begin
            o_row[j] = rd_data_s[j*C_WIDTH +: C_WIDTH];
        end
    end

    assign o_valid    = ~empty_s;
    assign o_overflow = overflow_q;
    assign o_skew_err = skew_err_q;
    assign o_row_cnt  = row_cnt_q;

endmodule

// File: tb/tb_sa_drain.sv
// Directed bench for sa_drain with SA_COLS=3, C_WIDTH=16, DEPTH=4.
module tb_sa_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vin [3];
    logic [15:0] din [3];
    logic        clr;
    logic        rdy;
    logic        o_valid;
    logic [15:0] o_row [3];
    logic [2:0]  o_count;
    logic        o_overflow;
    logic        o_skew_err;
    logic [15:0] o_row_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          max_cnt = 0;
    logic [63:0] got_q [$];
    int          got_cyc [$];

    sa_drain #(.SA_COLS(3), .C_WIDTH(16), .DEPTH(4)) dut (
        .i_clk               (clk),
        .i_rst               (rst_n),
        .i_ctrl_sa_send_data (vin),
        .i_c                 (din),
        .i_clr               (clr),
        .i_ready             (rdy),
        .o_valid             (o_valid),
        .o_row               (o_row),
        .o_count             (o_count),
        .o_overflow          (o_overflow),
        .o_skew_err          (o_skew_err),
        .o_row_cnt           (o_row_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every row handed downstream, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && rdy) begin
                got_q.push_back({16'h0, o_row[0], o_row[1], o_row[2]});
                got_cyc.push_back(cyc);
            end
            if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] row_of(input int k, input int base, input int step);
        logic [15:0] a, b, c;
        a = 16'(base + k);
        b = 16'(base + k + step);
        c = 16'(base + k + 2 * step);
        return {16'h0, a, b, c};
    endfunction

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Rows r=0..n-1 start on consecutive cycles; column j of row r arrives at cycle r+j.
    task automatic drive_rows(input int n, input int base, input int step, input int skip_r,
                              input logic rdy_base, input int ready_from);
        for (int c = 0; c < n + 2; c++) begin
            for (int j = 0; j < 3; j++) begin
                int r;
                r = c - j;
                if (r >= 0 && r < n && !(r == skip_r && j == 1)) begin
                    vin[j] = 1'b1;
                    din[j] = 16'(base + r + step * j);
                end else begin
                    vin[j] = 1'b0;
                    din[j] = 16'h0;
                end
            end
            rdy = rdy_base || (ready_from >= 0 && c >= ready_from);
            @(posedge clk);
            #1;
        end
        for (int j = 0; j < 3; j++) begin
            vin[j] = 1'b0;
            din[j] = 16'h0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        rdy   = 1'b0;
        for (int j = 0; j < 3; j++) begin
            vin[j] = 1'b0;
            din[j] = 16'h0;
        end
        step_cycles(2);
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_count", 64'(o_count), 64'd0);
        check_eq("rst_ovf", 64'(o_overflow), 64'd0);
        check_eq("rst_skew", 64'(o_skew_err), 64'd0);
        check_eq("rst_rowcnt", 64'(o_row_cnt), 64'd0);
        rst_n = 1'b1;
        step_cycles(1);

        // Single row {10,20,30}: visible the cycle after col2 arrives.
        drive_rows(1, 10, 10, -1, 1'b1, -1);
        check_eq("single_valid", 64'(o_valid), 64'd1);
        check_eq("single_row", {16'h0, o_row[0], o_row[1], o_row[2]}, row_of(0, 10, 10));
        check_eq("single_rowcnt", 64'(o_row_cnt), 64'd1);
        step_cycles(1);
        check_eq("single_drained", 64'(o_valid), 64'd0);
        step_cycles(1);

        // Back-to-back stream of 8 rows.
        got_q.delete();
        got_cyc.delete();
        max_cnt = 0;
        drive_rows(8, 0, 100, -1, 1'b1, -1);
        step_cycles(3);
        check_eq("stream_n", 64'(got_q.size()), 64'd8);
        for (int k = 0; k < got_q.size(); k++) check_eq("stream_row", got_q[k], row_of(k, 0, 100));
        if (got_cyc.size() == 8) check_eq("stream_span", 64'(got_cyc[7] - got_cyc[0]), 64'd7);
        check_eq("stream_maxcnt", 64'(max_cnt), 64'd1);
        check_eq("stream_ovf", 64'(o_overflow), 64'd0);
        check_eq("stream_skew", 64'(o_skew_err), 64'd0);
        check_eq("stream_rowcnt", 64'(o_row_cnt), 64'd9);

        // Overflow: five rows into a stalled FIFO of four.
        rdy = 1'b0;
        pulse_clr();
        check_eq("clr_rowcnt", 64'(o_row_cnt), 64'd0);
        drive_rows(5, 0, 100, -1, 1'b0, -1);
        check_eq("ovf_count", 64'(o_count), 64'd4);
        check_eq("ovf_flag", 64'(o_overflow), 64'd1);
        check_eq("ovf_rowcnt", 64'(o_row_cnt), 64'd4);
        got_q.delete();
        rdy = 1'b1;
        step_cycles(6);
        rdy = 1'b0;
        check_eq("ovf_drain_n", 64'(got_q.size()), 64'd4);
        for (int k = 0; k < got_q.size(); k++) check_eq("ovf_drain_row", got_q[k], row_of(k, 0, 100));
        check_eq("ovf_sticky", 64'(o_overflow), 64'd1);

        // Full FIFO with a pop in the same cycle the fifth row aligns.
        pulse_clr();
        check_eq("clr_ovf", 64'(o_overflow), 64'd0);
        got_q.delete();
        drive_rows(5, 0, 100, -1, 1'b0, 6);
        rdy = 1'b0;
        check_eq("fullpop_count", 64'(o_count), 64'd4);
        check_eq("fullpop_ovf", 64'(o_overflow), 64'd0);
        check_eq("fullpop_rowcnt", 64'(o_row_cnt), 64'd5);
        rdy = 1'b1;
        step_cycles(6);
        rdy = 1'b0;
        check_eq("fullpop_n", 64'(got_q.size()), 64'd5);
        for (int k = 0; k < got_q.size(); k++) check_eq("fullpop_row", got_q[k], row_of(k, 0, 100));

        // Skew error: row 1 loses its column-1 valid.
        pulse_clr();
        got_q.delete();
        drive_rows(3, 0, 100, 1, 1'b1, -1);
        step_cycles(2);
        check_eq("skew_flag", 64'(o_skew_err), 64'd1);
        check_eq("skew_ovf", 64'(o_overflow), 64'd0);
        check_eq("skew_rowcnt", 64'(o_row_cnt), 64'd2);
        check_eq("skew_n", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check_eq("skew_row0", got_q[0], row_of(0, 0, 100));
            check_eq("skew_row2", got_q[1], row_of(2, 0, 100));
        end
        pulse_clr();
        check_eq("skew_clr", 64'(o_skew_err), 64'd0);
        check_eq("skew_clr_rowcnt", 64'(o_row_cnt), 64'd0);

        // Reset while a row is half-way through the delay lines.
        rdy = 1'b0;
        drive_rows(1, 7, 1, -1, 1'b0, -1);
        check_eq("prerst_count", 64'(o_count), 64'd1);
        check_eq("prerst_rowcnt", 64'(o_row_cnt), 64'd1);
        vin[0] = 1'b1;
        din[0] = 16'd55;
        step_cycles(1);
        vin[0] = 1'b0;
        din[0] = 16'h0;
        vin[1] = 1'b1;
        din[1] = 16'd66;
        rst_n  = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(o_valid), 64'd0);
        check_eq("midrst_count", 64'(o_count), 64'd0);
        check_eq("midrst_rowcnt", 64'(o_row_cnt), 64'd0);
        check_eq("midrst_ovf", 64'(o_overflow), 64'd0);
        check_eq("midrst_skew", 64'(o_skew_err), 64'd0);
        vin[1] = 1'b0;
        din[1] = 16'h0;
        step_cycles(2);
        rst_n = 1'b1;
        got_q.delete();
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_cycles(1);
            check_eq("postrst_valid", 64'(o_valid), 64'd0);
        end
        check_eq("postrst_n", 64'(got_q.size()), 64'd0);
        check_eq("postrst_rowcnt", 64'(o_row_cnt), 64'd0);
        check_eq("postrst_skew", 64'(o_skew_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
